// File: rtl/serial_sub_pkg.sv
// Shared state encoding for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fsub_cell.sv
// One-bit full subtractor: d = x - y - c, bo is the borrow out of this bit.
module fsub_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ c;
  assign bo = (~x & y) | (~(x ^ y) & c);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one result bit per clock, LSB first, through a single fsub_cell.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   r_sr;
  logic               brw;
  logic               cell_d;
  logic               cell_bo;

  fsub_cell u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .c  (brw),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      brw   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bo    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            r_sr  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= {cell_d, r_sr[WIDTH-1:1]};
          brw  <= cell_bo;
          // Final bit: publish the completed word so d/bo are valid while done is high.
          if (cnt == LAST) begin
            d     <= {cell_d, r_sr[WIDTH-1:1]};
            bo    <= cell_bo;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: WIDTH=8 vector table plus corner sequences, WIDTH=2 exhaustive.
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8 instance
  logic       rst8, start8, bin8, busy8, done8, bo8;
  logic [7:0] a8, b8, d8;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst8),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .d     (d8),
    .bo    (bo8)
  );

  // WIDTH=2 instance
  logic       rst2, start2, bin2, busy2, done2, bo2;
  logic [1:0] a2, b2, d2;

  serial_sub #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst   (rst2),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .bin   (bin2),
    .busy  (busy2),
    .done  (done2),
    .d     (d2),
    .bo    (bo2)
  );

  typedef struct {
    logic [7:0] d;
    logic       bo;
  } exp8_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    int         mode;
  } vec_t;

  exp8_t      q8[$];
  logic [2:0] q2[$];
  exp8_t      mon_e8;
  logic [2:0] mon_e2;
  int         done_cnt8  = 0;
  int         last_done2 = -1;
  vec_t       tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      done_cnt8++;
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done8_unexpected actual=1 required=0 d=%0h", d8);
      end else begin
        mon_e8 = q8.pop_front();
        chk("d8", 64'(d8), 64'(mon_e8.d));
        chk("bo8", 64'(bo8), 64'(mon_e8.bo));
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done2_unexpected actual=1 required=0");
      end else begin
        mon_e2 = q2.pop_front();
        chk("d2", 64'(d2), 64'(mon_e2[1:0]));
        chk("bo2", 64'(bo2), 64'(mon_e2[2]));
      end
      if (last_done2 >= 0) chk("done2_spacing", 64'(cyc - last_done2), 64'd4);
      last_done2 = cyc;
    end
  end

  // mode 0: plain; 1: start pulsed mid-RUN with a=01; 2: inputs scrambled every RUN cycle
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                      input logic [7:0] ed, input logic ebo, input int mode);
    int    n;
    int    dc;
    exp8_t e;
    @(negedge clk);
    rst8   = 1'b0;
    a8     = ta;
    b8     = tb_;
    bin8   = tbin;
    start8 = 1'b1;
    e.d    = ed;
    e.bo   = ebo;
    q8.push_back(e);
    dc = done_cnt8;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    chk("busy8_run", 64'(busy8), 64'd1);
    for (n = 2; n <= 20; n++) begin
      @(negedge clk);
      if (mode == 1 && n == 4) begin
        start8 = 1'b1;
        a8     = 8'h01;
      end else begin
        start8 = 1'b0;
      end
      if (mode == 2) begin
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        bin8 = 1'($urandom);
      end
      @(posedge clk);
      #1;
      if (done8) break;
    end
    chk("latency8", 64'(n), 64'd9);
    chk("busy8_done", 64'(busy8), 64'd1);
    @(posedge clk);
    #1;
    chk("busy8_idle", 64'(busy8), 64'd0);
    chk("done8_pulse", 64'(done8), 64'd0);
    chk("d8_hold", 64'(d8), 64'(ed));
    if (mode == 1) begin
      repeat (12) @(posedge clk);
      #1;
      chk("extra_done8", 64'(done_cnt8 - dc), 64'd1);
    end
  endtask

  initial begin
    int k;
    logic [4:0] v;

    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    rst2 = 1'b1; start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;

    tbl[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bo: 1'b0, mode: 0};
    tbl[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, d: 8'hFE, bo: 1'b1, mode: 0};
    tbl[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bo: 1'b1, mode: 0};
    tbl[3] = '{a: 8'hFF, b: 8'h00, bin: 1'b0, d: 8'hFF, bo: 1'b0, mode: 1};
    tbl[4] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0, mode: 2};
    tbl[5] = '{a: 8'hAA, b: 8'h55, bin: 1'b1, d: 8'h54, bo: 1'b0, mode: 0};
    tbl[6] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, d: 8'hFF, bo: 1'b1, mode: 0};
    tbl[7] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1, mode: 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_d", 64'(d8), 64'd0);
    chk("rst_bo", 64'(bo8), 64'd0);

    for (int i = 0; i < 8; i++)
      run8(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, tbl[i].mode);

    // rst and start together: reset wins
    @(negedge clk);
    rst8 = 1'b1; start8 = 1'b1; a8 = 8'h44; b8 = 8'h11;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    chk("rst_prio_busy", 64'(busy8), 64'd0);
    run8(8'h21, 8'h12, 1'b0, 8'h0F, 1'b0, 0);

    // abort at RUN bit 4, then start in the first cycle after reset
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_d", 64'(d8), 64'd0);
    chk("abort_bo", 64'(bo8), 64'd0);
    run8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0);

    // WIDTH=2: all 32 operand combinations back-to-back
    @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      v      = 5'(i);
      a2     = v[4:3];
      b2     = v[2:1];
      bin2   = v[0];
      start2 = 1'b1;
      q2.push_back(3'({1'b0, a2} - {1'b0, b2} - {2'b00, bin2}));
      @(posedge clk);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (busy2 && k < 10);
    end
    start2 = 1'b0;

    k = 0;
    while ((q8.size() != 0 || q2.size() != 0) && k < 20) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
